// File: rtl/command_encoder_pkg.sv
// Shared definitions for the analyzer UART command protocol: opcodes, frame sizes
// and the encoder FSM state encoding.
package acsp_cmd_pkg;

   localparam logic [7:0] OP_RESET          = 8'h00;
   localparam logic [7:0] OP_RUN            = 8'h01;
   localparam logic [7:0] OP_ID             = 8'h02;
   localparam logic [7:0] OP_SET_DIVIDER    = 8'h80;
   localparam logic [7:0] OP_SET_READ_DELAY = 8'h81;
   localparam logic [7:0] OP_TRIG_MASK      = 8'hC0;
   localparam logic [7:0] OP_TRIG_VALUE     = 8'hC1;

   localparam int LONG_CMD_BIT     = 7;
   localparam int LONG_FRAME_BYTES = 5;
   localparam int PREAMBLE_BYTES   = 5;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_SEND      = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_IDLE = 2'd3
   } enc_state_t;

   function automatic logic [2:0] frame_bytes(input logic [7:0] opcode);
      return opcode[LONG_CMD_BIT] ? 3'(LONG_FRAME_BYTES) : 3'd1;
   endfunction

endpackage

// File: rtl/command_encoder_cmd_queue.sv
// Synchronous show-ahead FIFO holding {opcode, data} command entries; the head
// entry is readable combinationally while the queue is not empty.
module cmd_queue #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 40
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   output logic [WIDTH-1:0]             head_data,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push;
   logic             do_pop;

   // Full/empty come from the occupancy count so equal pointers are never ambiguous.
   always_comb begin
      full    = (count_q == CW'(DEPTH));
      empty   = (count_q == '0);
      do_push = push && !full;
      do_pop  = pop && !empty;

      wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

      count_d = count_q;
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   assign head_data = mem_q[rd_ptr_q];
   assign count     = count_q;

endmodule

// File: rtl/command_encoder.sv
// Host-side UART command transmitter: queues opcode/argument pairs and serializes
// them byte by byte through the trans_en/tx_busy handshake. CMD_ENC_PREAMBLE_EN adds send_reset.
//
// state        | meaning
// ST_IDLE      | waiting for a preamble request or a queued command
// ST_SEND      | trans_en strobe with tran_data holding the current byte
// ST_WAIT_BUSY | waiting for the UART to pick the byte up (tx_busy high)
// ST_WAIT_IDLE | waiting for the UART to finish the byte (tx_busy low)
module command_encoder
   import acsp_cmd_pkg::*;
#(
   parameter int QUEUE_DEPTH = 4
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic                               cmd_valid,
   input  logic [7:0]                         cmd_opcode,
   input  logic [31:0]                        cmd_data,
   output logic                               cmd_ready,
`ifdef CMD_ENC_PREAMBLE_EN
   input  logic                               send_reset,
`endif
   output logic                               trans_en,
   output logic [7:0]                         tran_data,
   input  logic                               tx_busy,
   output logic                               busy,
   output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_count
);

   localparam int CW = $clog2(QUEUE_DEPTH+1);

   enc_state_t    state_q, state_d;
   logic [2:0]    bytes_left_q, bytes_left_d;
   logic [31:0]   shift_q, shift_d;
   logic [7:0]    tran_data_q, tran_data_d;
   logic          pop;
   logic          q_full;
   logic          q_empty;
   logic [39:0]   head;
   logic [CW-1:0] q_count;

`ifdef CMD_ENC_PREAMBLE_EN
   logic [2:0]    pre_left_q, pre_left_d;
   logic          pre_pend_q, pre_pend_d;
`endif

   cmd_queue #(
      .DEPTH (QUEUE_DEPTH),
      .WIDTH (40)
   ) u_queue (
      .clock     (clock),
      .reset     (reset),
      .push      (cmd_valid && !q_full),
      .push_data ({cmd_opcode, cmd_data}),
      .pop       (pop),
      .head_data (head),
      .count     (q_count),
      .full      (q_full),
      .empty     (q_empty)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         bytes_left_q <= '0;
         shift_q      <= '0;
         tran_data_q  <= '0;
`ifdef CMD_ENC_PREAMBLE_EN
         pre_left_q   <= '0;
         pre_pend_q   <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         bytes_left_q <= bytes_left_d;
         shift_q      <= shift_d;
         tran_data_q  <= tran_data_d;
`ifdef CMD_ENC_PREAMBLE_EN
         pre_left_q   <= pre_left_d;
         pre_pend_q   <= pre_pend_d;
`endif
      end
   end

   always_comb begin
      state_d      = state_q;
      bytes_left_d = bytes_left_q;
      shift_d      = shift_q;
      tran_data_d  = tran_data_q;
      pop          = 1'b0;
`ifdef CMD_ENC_PREAMBLE_EN
      pre_left_d   = pre_left_q;
      // Requests arriving while a preamble is running merge into it.
      pre_pend_d   = pre_pend_q || (send_reset && (pre_left_q == 3'd0));
`endif

      unique case (state_q)
         ST_IDLE: begin
`ifdef CMD_ENC_PREAMBLE_EN
            if (pre_pend_q || send_reset) begin
               pre_pend_d  = 1'b0;
               pre_left_d  = 3'(PREAMBLE_BYTES);
               tran_data_d = 8'h00;
               state_d     = ST_SEND;
            end else
`endif
            if (!q_empty) begin
               pop          = 1'b1;
               tran_data_d  = head[39:32];
               shift_d      = head[31:0];
               bytes_left_d = frame_bytes(head[39:32]);
               state_d      = ST_SEND;
            end
         end
         ST_SEND: begin
            state_d = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (tx_busy) begin
               state_d = ST_WAIT_IDLE;
            end
         end
         ST_WAIT_IDLE: begin
            if (!tx_busy) begin
`ifdef CMD_ENC_PREAMBLE_EN
               if (pre_left_q != 3'd0) begin
                  pre_left_d = pre_left_q - 3'd1;
                  state_d    = (pre_left_q > 3'd1) ? ST_SEND : ST_IDLE;
               end else
`endif
               begin
                  bytes_left_d = bytes_left_q - 3'd1;
                  if (bytes_left_q > 3'd1) begin
                     // Argument bytes leave LSB first; tran_data only moves when a strobe follows.
                     tran_data_d = shift_q[7:0];
                     shift_d     = {8'h00, shift_q[31:8]};
                     state_d     = ST_SEND;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      trans_en    = (state_q == ST_SEND);
      tran_data   = tran_data_q;
      cmd_ready   = !q_full;
      busy        = (state_q != ST_IDLE) || !q_empty;
      queue_count = q_count;
   end

endmodule
